// File: rtl/io_controller.sv
// Memory-mapped IN/OUT port block: registered output ports written by OUT,
// and a button-handshaked IN that stalls the core until Set is pressed and released.
module io_controller #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 13,
  parameter int N_OUT           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    OpIO,
  input  logic                    Write,
  input  logic [DATA_W-1:0]       Endereco,
  input  logic [DATA_W-1:0]       DadosSaida,
  input  logic [SW_W-1:0]         Switches,
  input  logic                    Set,
  output logic [N_OUT*DATA_W-1:0] Output,
  output logic [DATA_W-1:0]       DataIO,
  output logic                    Halt,
  output logic                    Ready,
  output logic                    AddrErr
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       sync_q, sync_d;
  logic             set_s;
  logic             set_st_q, set_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;
  logic             press_evt;
  logic             rel_evt;

  logic [N_OUT-1:0][DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0]            data_q, data_d;
  logic                         ready_q, ready_d;
  logic                         aerr_q, aerr_d;
  logic                         halt_c;
  logic                         is_in;
  logic                         is_out;
  logic                         addr_ok;

  // Set is asynchronous and active-low; the synchroniser idles released (1).
  assign sync_d = {sync_q[0], Set};
  assign set_s  = sync_q[1];

  always_comb begin
    set_st_d = set_st_q;
    cnt_d    = '0;
    flip     = 1'b0;
    if (set_s != set_st_q) begin
      if (cnt_q == CNT_LAST) begin
        flip     = 1'b1;
        set_st_d = set_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Events fire on the same edge the stable level changes.
  assign press_evt = flip & set_st_q;
  assign rel_evt   = flip & ~set_st_q;

  assign is_in   = OpIO & ~Write;
  assign is_out  = OpIO & Write;
  assign addr_ok = (Endereco < DATA_W'(N_OUT));

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    data_d  = data_q;
    aerr_d  = 1'b0;
    halt_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_in) begin
          halt_c  = 1'b1;
          state_d = WAIT_PRESS;
        end else if (is_out) begin
          if (addr_ok) begin
            for (int k = 0; k < N_OUT; k++) begin
              if (Endereco == DATA_W'(k)) out_d[k] = DadosSaida;
            end
          end else begin
            aerr_d = 1'b1;
          end
        end
      end
      WAIT_PRESS: begin
        halt_c = 1'b1;
        if (press_evt) begin
          data_d  = DATA_W'(Switches);
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        halt_c = 1'b1;
        if (rel_evt) state_d = DONE;
      end
      DONE: begin
        // Halt low here lets the core retire the IN exactly once.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_d = (state_d == DONE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_q   <= 2'b11;
      set_st_q <= 1'b1;
      cnt_q    <= '0;
      state_q  <= IDLE;
      out_q    <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      set_st_q <= set_st_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      out_q    <= out_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      aerr_q   <= aerr_d;
    end
  end

  assign Output  = out_q;
  assign DataIO  = data_q;
  assign Halt    = halt_c;
  assign Ready   = ready_q;
  assign AddrErr = aerr_q;

endmodule

// File: tb/tb_io_controller.sv
// Scoreboard bench for io_controller: expected IN results and AddrErr port
// snapshots are queued at stimulus time and popped by a negedge monitor.
module tb_io_controller;

  localparam int DATA_W = 32;
  localparam int SW_W   = 13;
  localparam int N_OUT  = 4;
  localparam int D      = 4;
  localparam int OW     = N_OUT * DATA_W;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              OpIO = 1'b0;
  logic              Write = 1'b0;
  logic [DATA_W-1:0] Endereco = '0;
  logic [DATA_W-1:0] DadosSaida = '0;
  logic [SW_W-1:0]   Switches = '0;
  logic              Set = 1'b1;
  logic [OW-1:0]     Output;
  logic [DATA_W-1:0] DataIO;
  logic              Halt;
  logic              Ready;
  logic              AddrErr;

  io_controller #(
    .DATA_W(DATA_W), .SW_W(SW_W), .N_OUT(N_OUT), .DEBOUNCE_CYCLES(D)
  ) dut (
    .Clock(Clock), .Reset(Reset), .OpIO(OpIO), .Write(Write),
    .Endereco(Endereco), .DadosSaida(DadosSaida), .Switches(Switches), .Set(Set),
    .Output(Output), .DataIO(DataIO), .Halt(Halt), .Ready(Ready), .AddrErr(AddrErr)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] model_port [N_OUT];
  logic [DATA_W-1:0] rdy_q [$];
  logic [OW-1:0]     aerr_q [$];

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] model_flat();
    logic [OW-1:0] f;
    for (int k = 0; k < N_OUT; k++) f[k*DATA_W +: DATA_W] = model_port[k];
    return f;
  endfunction

  always @(negedge Clock) begin
    if (!Reset) begin
      if (Ready) begin
        if (rdy_q.size() == 0) chk("unexpected_ready", Ready, 0);
        else begin
          chk("dataio_on_ready", DataIO, rdy_q.pop_front());
          chk("halt_in_done", Halt, 0);
        end
      end
      if (AddrErr) begin
        if (aerr_q.size() == 0) chk("unexpected_addrerr", AddrErr, 0);
        else chk("ports_unchanged_on_addrerr", Output, aerr_q.pop_front());
      end
    end
  end

  task automatic wait_ready(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge Clock);
      if (Ready) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ready_timeout: Ready got 0 expected 1 within %0d cycles", bound);
    end
  endtask

  task automatic do_out(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge Clock);
    #1 OpIO = 1'b1; Write = 1'b1; Endereco = a; DadosSaida = d;
    @(negedge Clock);
    chk("halt_on_out", Halt, 0);
    if (a < N_OUT) model_port[int'(a)] = d;
    else aerr_q.push_back(model_flat());
    @(posedge Clock);
    #1 OpIO = 1'b0; Write = 1'b0;
    @(negedge Clock);
    chk("out_ports", Output, model_flat());
    chk("addrerr_pulse", AddrErr, (a >= N_OUT));
  endtask

  task automatic issue_in(input logic [SW_W-1:0] sw);
    @(posedge Clock);
    #1 OpIO = 1'b1; Write = 1'b0; Switches = sw;
    @(negedge Clock);
    chk("halt_on_decode", Halt, 1);
  endtask

  // Set low for exactly n sampling edges, then released.
  task automatic low_pulse(input int n);
    @(posedge Clock);
    #1 Set = 1'b0;
    repeat (n) @(posedge Clock);
    #1 Set = 1'b1;
  endtask

  task automatic finish_in();
    wait_ready(60);
    @(posedge Clock);
    #1 OpIO = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW_W-1:0]   sw;
    logic [DATA_W-1:0] a;
    for (int k = 0; k < N_OUT; k++) model_port[k] = '0;

    repeat (3) @(posedge Clock);
    #2;
    chk("reset_output", Output, 0);
    chk("reset_dataio", DataIO, 0);
    chk("reset_ready", Ready, 0);
    chk("reset_addrerr", AddrErr, 0);
    chk("reset_halt", Halt, 0);
    @(posedge Clock);
    #1 Reset = 1'b0;

    do_out(0, 32'h11);
    do_out(1, 32'h22);
    do_out(2, 32'h33);
    do_out(3, 32'hDEADBEEF);
    do_out(4, 32'hFF);
    do_out(32'h100, 32'hFF);
    do_out(32'h8000_0001, 32'h1234_5678);

    // Directed IN: capture exactly 2+D cycles after the fall, Ready 2+D after the rise.
    issue_in(13'h1ABC);
    rdy_q.push_back(32'h0000_1ABC);
    @(posedge Clock);
    #1 Set = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge Clock);
      #2;
      chk("halt_waiting_press", Halt, 1);
      if (i == 5) chk("dataio_before_capture", DataIO, 0);
      if (i == 6) chk("dataio_at_capture", DataIO, 32'h0000_1ABC);
    end
    Set = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge Clock);
      #2;
      if (i == 5) begin
        chk("ready_before_release", Ready, 0);
        chk("halt_waiting_release", Halt, 1);
      end
      if (i == 6) begin
        chk("ready_after_release", Ready, 1);
        chk("halt_low_done", Halt, 0);
      end
    end
    @(posedge Clock);
    #1 OpIO = 1'b0;
    #1;
    chk("ready_one_cycle", Ready, 0);
    chk("halt_idle_after_in", Halt, 0);

    // Short glitches and a stray OUT while stalled must be ignored.
    issue_in(13'h0F0F);
    @(posedge Clock);
    #1 Write = 1'b1; Endereco = 1; DadosSaida = 32'hBAD0_BAD0;
    repeat (2) @(posedge Clock);
    #1 Write = 1'b0;
    for (int g = 1; g < D; g++) begin
      low_pulse(g);
      repeat (3) @(posedge Clock);
    end
    repeat (D + 2) @(posedge Clock);
    #2;
    chk("dataio_after_glitches", DataIO, 32'h0000_1ABC);
    chk("ports_after_stalled_out", Output, model_flat());
    chk("halt_after_glitches", Halt, 1);
    rdy_q.push_back(32'h0000_0F0F);
    low_pulse(D + 1);
    finish_in();

    // Button already held when the IN arrives: needs release then fresh press.
    @(posedge Clock);
    #1 Set = 1'b0;
    repeat (D + 4) @(posedge Clock);
    issue_in(13'h0555);
    repeat (D + 6) @(posedge Clock);
    #2;
    chk("no_capture_held_low", DataIO, 32'h0000_0F0F);
    chk("halt_held_low", Halt, 1);
    @(posedge Clock);
    #1 Set = 1'b1;
    repeat (D + 4) @(posedge Clock);
    #2;
    chk("no_capture_on_release", DataIO, 32'h0000_0F0F);
    rdy_q.push_back(32'h0000_0555);
    low_pulse(D + 2);
    finish_in();

    // Back-to-back IN: OpIO stays asserted through DONE.
    issue_in(13'h1001);
    rdy_q.push_back(32'h0000_1001);
    low_pulse(D + 1);
    wait_ready(60);
    Switches = 13'h0777;
    @(posedge Clock);
    #2;
    chk("halt_b2b_idle", Halt, 1);
    chk("ready_b2b_idle", Ready, 0);
    @(posedge Clock);
    #2;
    chk("halt_b2b_wait", Halt, 1);
    rdy_q.push_back(32'h0000_0777);
    low_pulse(D + 3);
    finish_in();

    // Reset while in WAIT_RELEASE.
    issue_in(13'h1234);
    @(posedge Clock);
    #1 Set = 1'b0;
    repeat (D + 4) @(posedge Clock);
    #2;
    chk("dataio_before_reset", DataIO, 32'h0000_1234);
    chk("halt_before_reset", Halt, 1);
    Reset = 1'b1; OpIO = 1'b0; Set = 1'b1;
    #1;
    chk("mid_reset_dataio", DataIO, 0);
    chk("mid_reset_output", Output, 0);
    chk("mid_reset_halt", Halt, 0);
    chk("mid_reset_ready", Ready, 0);
    for (int k = 0; k < N_OUT; k++) model_port[k] = '0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;

    // Randomized mix of OUT and IN transactions.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        sw = SW_W'($urandom);
        issue_in(sw);
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          low_pulse(int'($urandom_range(1, D - 1)));
          repeat ($urandom_range(2, 4)) @(posedge Clock);
        end
        rdy_q.push_back(DATA_W'(sw));
        low_pulse(int'($urandom_range(D, D + 6)));
        repeat (3) @(posedge Clock);
        #1 Switches = SW_W'($urandom);
        finish_in();
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: a = DATA_W'($urandom_range(0, N_OUT - 1));
          6, 7:             a = DATA_W'(N_OUT + $urandom_range(0, 3));
          default:          a = $urandom;
        endcase
        do_out(a, $urandom);
      end
    end

    repeat (3) @(posedge Clock);
    #2;
    chk("ready_queue_drained", rdy_q.size(), 0);
    chk("addrerr_queue_drained", aerr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
